// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Sequencer for a multi-cycle MIPS datapath in which PC, IR, A/B and ALUOut
//   are registers. Each instruction is stepped through fetch, decode, execute,
//   memory and write-back states. All datapath strobes are decoded from the
//   current state plus mem_ready_i and zero_i.
//
//   Memory accesses in FETCH, MEM_RD and MEM_WR wait for mem_ready_i. A wait
//   counter aborts the access with a one-cycle bus_error_o pulse after
//   MEM_TIMEOUT unready cycles. The sequencer then returns to FETCH, and the
//   same PC is fetched again.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opcode_i[5:0]     IR[31:26]; must be stable from DECODE to instruction end
//   zero_i            ALU zero flag (branch decision)
//   mem_ready_i       memory access completes this cycle
//   pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, mem_to_reg_o,
//   reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o[1:0], alu_op_o[3:0],
//   pc_source_o[1:0]  datapath strobes and mux selects
//   instr_done_o      pulse on the last cycle of each instruction
//   illegal_o         pulse when DECODE sees an unsupported opcode
//   bus_error_o       pulse when a memory access times out
//   state_o[3:0]      current state, for debug
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       bus_error_o,
  output logic [3:0] state_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_R   = 4'b0111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    I_EXEC   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             timeout;

  // ALU function for the immediate arithmetic/logic group
  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ORI:  return ALU_OR;
      OP_ANDI: return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  assign waiting = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // Ready arriving on the limit cycle wins over the timeout
  assign timeout = waiting && !mem_ready_i && (wait_cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      // A timeout in FETCH keeps the state, so it must clear explicitly
      if ((next_state != state) || timeout)
        wait_cnt <= '0;
      else if (waiting && !mem_ready_i)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state   = state;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_dst_o    = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = ALU_ADD;
    pc_source_o  = 2'b00;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    bus_error_o  = 1'b0;
    state_o      = state;

    case (state)
      FETCH: begin
        // PC+4 is computed in the ALU while the instruction is read
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          next_state = DECODE;
        end else if (timeout) begin
          bus_error_o = 1'b1;
        end
      end
      DECODE: begin
        // Branch target is speculatively computed into ALUOut
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_RTYPE:                 next_state = R_EXEC;
          OP_ADDI, OP_ORI, OP_ANDI: next_state = I_EXEC;
          OP_LW, OP_SW:             next_state = MEM_ADDR;
          OP_BEQ, OP_BNE:           next_state = BRANCH;
          OP_J:                     next_state = JUMP;
          default: begin
            illegal_o  = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        next_state  = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (mem_ready_i) begin
          next_state = MEM_WB;
        end else if (timeout) begin
          bus_error_o = 1'b1;
          next_state  = FETCH;
        end
      end
      MEM_WB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        next_state   = FETCH;
      end
      MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          next_state   = FETCH;
        end else if (timeout) begin
          bus_error_o = 1'b1;
          next_state  = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_R;
        next_state  = R_WB;
      end
      R_WB: begin
        reg_dst_o    = 1'b1;
        reg_write_o  = 1'b1;
        alu_op_o     = ALU_R;
        instr_done_o = 1'b1;
        next_state   = FETCH;
      end
      I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = imm_alu_op(opcode_i);
        next_state  = I_WB;
      end
      I_WB: begin
        // ALU inputs are held so ALUOut-free write-back still sees the result
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b10;
        alu_op_o     = imm_alu_op(opcode_i);
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        next_state   = FETCH;
      end
      BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = ALU_SUB;
        pc_source_o  = 2'b01;
        pc_write_o   = (opcode_i == OP_BEQ) ? zero_i : ~zero_i;
        instr_done_o = 1'b1;
        next_state   = FETCH;
      end
      JUMP: begin
        pc_source_o  = 2'b10;
        pc_write_o   = 1'b1;
        instr_done_o = 1'b1;
        next_state   = FETCH;
      end
      default: next_state = FETCH;
    endcase

    // Reset aborts the instruction; no strobe may fire in the reset cycle
    if (reset) begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      i_or_d_o     = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_dst_o    = 1'b0;
      reg_write_o  = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = ALU_ADD;
      pc_source_o  = 2'b00;
      instr_done_o = 1'b0;
      illegal_o    = 1'b0;
      bus_error_o  = 1'b0;
      state_o      = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks instruction sequences cycle
// by cycle and compares strobes against hand-derived values.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o;
  logic       mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [3:0] alu_op_o, state_o;
  logic       instr_done_o, illegal_o, bus_error_o;

  int passed = 0;
  int total  = 0;

  multicycle_control_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .ir_write_o(ir_write_o),
    .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .pc_source_o(pc_source_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o),
    .bus_error_o(bus_error_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs set here apply to
  // the new cycle, and checks follow after a further #1.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode_i = 6'h00; zero_i = 1'b0; mem_ready_i = 1'b1;

    // Reset: two cycles, every output quiet
    cyc(); #1;
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_mem_read", 8'(mem_read_o), 8'd0);
    chk("rst_pc_write", 8'(pc_write_o), 8'd0);
    cyc(); #1;
    chk("rst_ir_write", 8'(ir_write_o), 8'd0);

    // R-type with zero-wait memory: 0,1,6,7,0
    cyc(); reset = 1'b0; opcode_i = 6'h00; #1;
    chk("r_fetch_state", 8'(state_o), 8'd0);
    chk("r_fetch_strobes", {4'b0, mem_read_o, ir_write_o, pc_write_o, i_or_d_o}, 8'b1110);
    chk("r_fetch_srcb", 8'(alu_src_b_o), 8'd1);
    cyc(); #1;
    chk("r_decode_state", 8'(state_o), 8'd1);
    chk("r_decode_srcb", 8'(alu_src_b_o), 8'd3);
    cyc(); #1;
    chk("r_exec_state", 8'(state_o), 8'd6);
    chk("r_exec_aluop", 8'(alu_op_o), 8'd7);
    chk("r_exec_srca", 8'(alu_src_a_o), 8'd1);
    cyc(); #1;
    chk("r_wb_state", 8'(state_o), 8'd7);
    chk("r_wb_strobes", {5'b0, reg_write_o, reg_dst_o, instr_done_o}, 8'b111);
    cyc(); #1;
    chk("r_next_state", 8'(state_o), 8'd0);
    chk("r_done_once", 8'(instr_done_o), 8'd0);

    // lw with ready low for 3 cycles in MEM_RD
    opcode_i = 6'h23;
    cyc(); #1;
    chk("lw_decode", 8'(state_o), 8'd1);
    cyc(); #1;
    chk("lw_addr_state", 8'(state_o), 8'd2);
    chk("lw_addr_src", {4'b0, alu_src_a_o, 1'b0, alu_src_b_o}, 8'b1010);
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_ready_i = 1'b0; #1;
      chk("lw_rd_hold", 8'(state_o), 8'd3);
      chk("lw_rd_strobes", {5'b0, mem_read_o, i_or_d_o, reg_write_o}, 8'b110);
    end
    cyc(); mem_ready_i = 1'b1; #1;
    chk("lw_rd_ready", 8'(state_o), 8'd3);
    cyc(); #1;
    chk("lw_wb_state", 8'(state_o), 8'd4);
    chk("lw_wb_strobes", {4'b0, mem_to_reg_o, reg_write_o, reg_dst_o, instr_done_o}, 8'b1101);

    // beq taken (zero=1)
    opcode_i = 6'h04; zero_i = 1'b1;
    cyc(); cyc(); cyc(); #1;
    chk("beq_state", 8'(state_o), 8'd10);
    chk("beq_pc_write", 8'(pc_write_o), 8'd1);
    chk("beq_src", {2'b0, pc_source_o, alu_op_o}, 8'b010001);
    chk("beq_done", 8'(instr_done_o), 8'd1);

    // bne with zero=1: not taken; then zero=0 in the same cycle: taken
    cyc(); opcode_i = 6'h05; cyc(); cyc(); #1;
    chk("bne_state", 8'(state_o), 8'd10);
    chk("bne_z1_pc_write", 8'(pc_write_o), 8'd0);
    zero_i = 1'b0; #1;
    chk("bne_z0_pc_write", 8'(pc_write_o), 8'd1);

    // Illegal opcode
    cyc(); opcode_i = 6'h3F; #1;
    chk("ill_fetch", 8'(state_o), 8'd0);
    cyc(); #1;
    chk("ill_pulse", 8'(illegal_o), 8'd1);
    chk("ill_no_writes", {4'b0, reg_write_o, mem_write_o, pc_write_o, ir_write_o}, 8'd0);
    cyc(); mem_ready_i = 1'b0; #1;
    chk("ill_next_fetch", 8'(state_o), 8'd0);
    chk("ill_pulse_end", 8'(illegal_o), 8'd0);

    // Fetch timeout: that cycle was unready #1; 15 more reach the limit
    for (int i = 2; i <= 15; i++) begin
      cyc(); #1;
      chk("to_wait_no_err", {6'b0, bus_error_o, pc_write_o}, 8'd0);
    end
    cyc(); #1;
    chk("to_bus_error", 8'(bus_error_o), 8'd1);
    chk("to_no_pc_write", {6'b0, pc_write_o, ir_write_o}, 8'd0);
    cyc(); #1;
    chk("to_refetch_state", 8'(state_o), 8'd0);
    chk("to_counter_clear", 8'(bus_error_o), 8'd0);

    // Retry succeeds: jump
    mem_ready_i = 1'b1; opcode_i = 6'h02; #1;
    chk("retry_ir_write", 8'(ir_write_o), 8'd1);
    cyc(); cyc(); #1;
    chk("j_state", 8'(state_o), 8'd11);
    chk("j_strobes", {3'b0, pc_source_o, pc_write_o, instr_done_o, 1'b0}, 8'b10110);

    // Ready on the limit cycle wins
    cyc(); mem_ready_i = 1'b0; opcode_i = 6'h0D;
    for (int i = 0; i < 14; i++) cyc();
    #1;
    chk("race_pre_state", 8'(state_o), 8'd0);
    cyc(); mem_ready_i = 1'b1; #1;
    chk("race_no_error", {6'b0, bus_error_o, ir_write_o}, 8'b01);

    // ori: I_EXEC / I_WB with OR
    cyc(); cyc(); #1;
    chk("ori_exec", {state_o, alu_op_o}, {4'd8, 4'b0011});
    cyc(); #1;
    chk("ori_wb", {state_o, alu_op_o}, {4'd9, 4'b0011});
    chk("ori_wb_strobes", {5'b0, reg_write_o, reg_dst_o, instr_done_o}, 8'b101);

    // sw, then reset asserted during MEM_WR with ready=1
    cyc(); opcode_i = 6'h2B; cyc(); cyc(); cyc(); #1;
    chk("sw_wr_state", 8'(state_o), 8'd5);
    chk("sw_wr_strobes", {5'b0, mem_write_o, i_or_d_o, instr_done_o}, 8'b111);
    cyc(); cyc(); cyc(); cyc(); reset = 1'b1; #1;
    chk("rst_mid_mem_write", 8'(mem_write_o), 8'd0);
    chk("rst_mid_state_o", 8'(state_o), 8'd0);
    cyc(); reset = 1'b0; #1;
    chk("rst_mid_next", 8'(state_o), 8'd0);
    chk("rst_mid_fetch_read", 8'(mem_read_o), 8'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
